instr_align_buffer: RTL and testbench

INSTR_ALIGN_BUFFER -- requirements
Module: instr_align_buffer

---
 rtl/instr_align_buffer.sv | 102 ++++++++++
 tb/tb_instr_align_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_align_buffer.sv
// Instruction alignment buffer: splits fetch words into 16-bit parcels and
// reassembles them into RVC / 32-bit instructions with their PCs.
module instr_align_buffer #(
   parameter int          FETCH_W  = 32,
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [31:0]                flush_pc,
   input  logic                       fetch_valid,
   output logic                       fetch_ready,
   input  logic [FETCH_W-1:0]         fetch_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [31:0]                out_pc,
   output logic                       out_is_rvc,
   output logic [$clog2(DEPTH):0]     parcel_cnt
);

   localparam int NP   = FETCH_W / 16;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam int OFFW = $clog2(NP);
   localparam int OFFB = $clog2(FETCH_W / 8);

   localparam logic [0:0] ALIGN = 1'b0;
   localparam logic [0:0] RUN   = 1'b1;

   logic [15:0]     mem [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   cnt;
   logic [31:0]     pc;
   logic [0:0]      state;

   logic [15:0]     p0;
   logic [15:0]     p1;
   logic            head_rvc;
   logic            push;
   logic            pop;
   logic [OFFW-1:0] drop;
   logic [CW-1:0]   push_n;
   logic [CW-1:0]   pop_n;

   assign p0 = mem[head];
   assign p1 = mem[head + PW'(1)];

   // An empty buffer reports a non-RVC head so the reset outputs read all zero.
   assign head_rvc    = (p0[1:0] != 2'b11) && (cnt != '0);
   assign out_is_rvc  = head_rvc;
   assign out_instr   = head_rvc ? {16'h0000, p0} : {p1, p0};
   assign out_pc      = pc;
   assign out_valid   = head_rvc ? (cnt >= CW'(1)) : (cnt >= CW'(2));
   assign parcel_cnt  = cnt;

   assign fetch_ready = !flush && ((CW'(DEPTH) - cnt) >= CW'(NP));

   // Only the first word after a redirect is trimmed of parcels below the PC.
   assign drop   = (state == ALIGN) ? pc[OFFB-1:1] : '0;
   assign push   = fetch_valid && fetch_ready;
   assign pop    = out_valid && out_ready && !flush;
   assign push_n = push ? (CW'(NP) - CW'(drop)) : '0;
   assign pop_n  = pop ? (head_rvc ? CW'(1) : CW'(2)) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         head  <= '0;
         tail  <= '0;
         cnt   <= '0;
         pc    <= RESET_PC;
         state <= ALIGN;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= '0;
         pc    <= flush_pc & 32'hFFFF_FFFE;
         state <= ALIGN;
      end else begin
         if (push) begin
            for (int i = 0; i < NP; i++) begin
               if (i >= int'(drop)) begin
                  mem[tail + PW'(i) - PW'(drop)] <= fetch_data[16*i +: 16];
               end
            end
            tail  <= tail + PW'(push_n);
            state <= RUN;
         end
         if (pop) begin
            head <= head + PW'(pop_n);
            pc   <= pc + (head_rvc ? 32'd2 : 32'd4);
         end
         cnt <= cnt + push_n - pop_n;
      end
   end

endmodule

// File: tb/tb_instr_align_buffer.sv
// Scoreboard bench for instr_align_buffer: a parcel-stream model produces the
// expected instruction sequence, a monitor pops and compares on every handshake.
module tb_instr_align_buffer;

   localparam int          FETCH_W  = 32;
   localparam int          DEPTH    = 8;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          NP       = FETCH_W / 16;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   flush = 1'b0;
   logic [31:0]            flush_pc = '0;
   logic                   fetch_valid = 1'b0;
   logic                   fetch_ready;
   logic [FETCH_W-1:0]     fetch_data = '0;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [31:0]            out_instr;
   logic [31:0]            out_pc;
   logic                   out_is_rvc;
   logic [$clog2(DEPTH):0] parcel_cnt;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        rvc;
   } exp_t;

   exp_t        expq[$];
   logic [15:0] pq[$];
   int          mcnt = 0;
   logic [31:0] mpc = RESET_PC;
   bit          malign = 1'b1;
   int          mon_pop = 0;
   int          checks = 0;
   int          errors = 0;

   instr_align_buffer #(
      .FETCH_W  (FETCH_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .fetch_valid (fetch_valid),
      .fetch_ready (fetch_ready),
      .fetch_data  (fetch_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_is_rvc  (out_is_rvc),
      .parcel_cnt  (parcel_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput(input string name, input logic v, input logic [31:0] instr,
                              input logic [31:0] pc, input logic rvc);
      checkValue({name, ".valid"}, 32'(out_valid), 32'(v));
      if (v) begin
         checkValue({name, ".instr"}, out_instr, instr);
         checkValue({name, ".pc"}, out_pc, pc);
         checkValue({name, ".rvc"}, 32'(out_is_rvc), 32'(rvc));
      end
   endtask

   task automatic applyStimulus(input logic fv, input logic [FETCH_W-1:0] fd, input logic ordy,
                                input logic fl, input logic [31:0] fpc);
      fetch_valid = fv;
      fetch_data  = fd;
      out_ready   = ordy;
      flush       = fl;
      flush_pc    = fpc;
   endtask

   task automatic step(input logic fv, input logic [FETCH_W-1:0] fd, input logic ordy,
                       input logic fl, input logic [31:0] fpc);
      applyStimulus(fv, fd, ordy, fl, fpc);
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
      flush       = 1'b0;
   endtask

   // Reference model: parcels form instructions as soon as they are complete.
   initial forever begin
      bit rdy;
      int skip;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         pq.delete(); expq.delete();
         mcnt = 0; mpc = RESET_PC; malign = 1'b1; mon_pop = 0;
      end else if (flush) begin
         pq.delete(); expq.delete();
         mcnt = 0; mpc = flush_pc & 32'hFFFF_FFFE; malign = 1'b1; mon_pop = 0;
      end else begin
         rdy = (DEPTH - mcnt) >= NP;
         mcnt = mcnt - mon_pop;
         mon_pop = 0;
         if (fetch_valid && rdy) begin
            skip = malign ? int'(mpc % 32'(FETCH_W / 8)) / 2 : 0;
            for (int i = 0; i < NP; i++) begin
               if (i >= skip) begin
                  pq.push_back(fetch_data[16*i +: 16]);
                  mcnt++;
               end
            end
            malign = 1'b0;
            while (pq.size() > 0) begin
               if (pq[0][1:0] != 2'b11) begin
                  expq.push_back('{instr: {16'h0000, pq[0]}, pc: mpc, rvc: 1'b1});
                  void'(pq.pop_front());
                  mpc = mpc + 32'd2;
               end else if (pq.size() >= 2) begin
                  expq.push_back('{instr: {pq[1], pq[0]}, pc: mpc, rvc: 1'b0});
                  void'(pq.pop_front());
                  void'(pq.pop_front());
                  mpc = mpc + 32'd4;
               end else begin
                  break;
               end
            end
         end
      end
   end

   // Monitor: compares every cycle and consumes the expected head on a handshake.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n) begin
         checkValue("fetch_ready", 32'(fetch_ready), 32'(!flush && ((DEPTH - mcnt) >= NP)));
         checkValue("parcel_cnt", 32'(parcel_cnt), 32'(mcnt));
         checkValue("out_valid", 32'(out_valid), 32'(expq.size() > 0));
         if (out_valid && expq.size() > 0) begin
            e = expq[0];
            checkValue("sb.instr", out_instr, e.instr);
            checkValue("sb.pc", out_pc, e.pc);
            checkValue("sb.rvc", 32'(out_is_rvc), 32'(e.rvc));
            if (out_ready && !flush) begin
               void'(expq.pop_front());
               mon_pop = e.rvc ? 1 : 2;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #3;
      checkOutput("reset", 1'b0, '0, '0, 1'b0);
      checkValue("reset.instr", out_instr, 32'h0);
      checkValue("reset.rvc", 32'(out_is_rvc), 32'h0);
      checkValue("reset.pc", out_pc, RESET_PC);
      checkValue("reset.cnt", 32'(parcel_cnt), 32'h0);
      checkValue("reset.fetch_ready", 32'(fetch_ready), 32'h1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      step(1'b1, 32'h0010_0093, 1'b0, 1'b0, '0);
      checkOutput("addi", 1'b1, 32'h0010_0093, 32'h0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, '0);
      checkOutput("addi_done", 1'b0, '0, '0, 1'b0);

      step(1'b0, '0, 1'b0, 1'b1, 32'h0);
      step(1'b1, 32'h4505_0001, 1'b0, 1'b0, '0);
      checkOutput("cnop", 1'b1, 32'h0000_0001, 32'h0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, '0);
      checkOutput("cli", 1'b1, 32'h0000_4505, 32'h2, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, '0);
      checkOutput("cli_done", 1'b0, '0, '0, 1'b0);

      step(1'b0, '0, 1'b0, 1'b1, 32'h0);
      step(1'b1, 32'h0093_0001, 1'b0, 1'b0, '0);
      checkOutput("straddle_cnop", 1'b1, 32'h0000_0001, 32'h0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, '0);
      checkOutput("straddle_wait", 1'b0, '0, '0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("straddle_hold", 1'b0, '0, '0, 1'b0);
      step(1'b1, 32'h1234_0010, 1'b0, 1'b0, '0);
      checkOutput("straddle_addi", 1'b1, 32'h0010_0093, 32'h2, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, '0);
      checkOutput("straddle_tail", 1'b1, 32'h0000_1234, 32'h6, 1'b1);

      step(1'b0, '0, 1'b0, 1'b1, 32'h0000_0102);
      step(1'b1, 32'hAAAA_4505, 1'b0, 1'b0, '0);
      checkOutput("align_drop", 1'b1, 32'h0000_AAAA, 32'h0000_0102, 1'b1);
      checkValue("align_drop.cnt", 32'(parcel_cnt), 32'h1);

      step(1'b0, '0, 1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h0010_0093, 1'b0, 1'b0, '0);
      checkValue("fill.cnt", 32'(parcel_cnt), 32'h8);
      checkValue("fill.fetch_ready", 32'(fetch_ready), 32'h0);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
      checkValue("fill.ignored", 32'(parcel_cnt), 32'h8);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
      #1;
      checkValue("fill.pop_same_cycle", 32'(fetch_ready), 32'h0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkValue("fill.after_pop_cnt", 32'(parcel_cnt), 32'h6);
      checkValue("fill.after_pop_ready", 32'(fetch_ready), 32'h1);

      applyStimulus(1'b1, 32'h0001_0001, 1'b1, 1'b1, 32'h0000_0200);
      #1;
      checkValue("flush.fetch_ready", 32'(fetch_ready), 32'h0);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkValue("flush.cnt", 32'(parcel_cnt), 32'h0);
      checkValue("flush.valid", 32'(out_valid), 32'h0);
      checkValue("flush.pc", out_pc, 32'h0000_0200);

      step(1'b1, 32'h0093_0001, 1'b0, 1'b0, '0);
      step(1'b0, '0, 1'b1, 1'b0, '0);
      checkValue("half.cnt", 32'(parcel_cnt), 32'h1);
      out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checkValue("rst_mid.valid", 32'(out_valid), 32'h0);
      checkValue("rst_mid.cnt", 32'(parcel_cnt), 32'h0);
      checkValue("rst_mid.pc", out_pc, RESET_PC);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 32'h0010_0093, 1'b0, 1'b0, '0);
      checkOutput("after_rst", 1'b1, 32'h0010_0093, RESET_PC, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         step(($urandom % 10) < 7, FETCH_W'($urandom), ($urandom % 10) < 6,
              ($urandom % 64) == 0, $urandom);
         if (($urandom % 400) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
      end
      step(1'b0, '0, 1'b1, 1'b0, '0);
      repeat (4) step(1'b0, '0, 1'b1, 1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
